// File: rtl/przycisk_debounce.sv
`default_nettype none
// ============================================================================
// Module   : przycisk_debounce
// Brief    : Synchronises and debounces the step key and direction switch,
//            and produces ADD_SUB plus a 1-cycle STEP enable with auto-repeat.
// Revision : 1.0 - initial release
// ============================================================================
module przycisk_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_PERIOD   = 12_587_500
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN_N,
    input  logic SW_DIR,
    output logic ADD_SUB,
    output logic STEP,
    output logic PRESSED
);

    localparam int c_MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int c_MAX   = (c_MAX_A > REPEAT_PERIOD) ? c_MAX_A : REPEAT_PERIOD;
    localparam int c_CNT_W = $clog2(c_MAX) + 1;

    localparam logic [c_CNT_W-1:0] c_CNT_ZERO = '0;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = '1;
    localparam logic [c_CNT_W-1:0] c_DEB_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_RD_LAST  = c_CNT_W'(REPEAT_DELAY - 1);
    localparam logic [c_CNT_W-1:0] c_RP_LAST  = c_CNT_W'(REPEAT_PERIOD - 1);
    localparam bit                 c_REPEAT   = (REPEAT_EN != 0);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DEB_PRESS = 3'd1,
        ST_HELD      = 3'd2,
        ST_REPEAT    = 3'd3,
        ST_DEB_REL   = 3'd4
    } state_t;

    logic               r_btn_sync1;
    logic               r_btn_sync2;
    logic               r_sw_sync1;
    logic               r_sw_sync2;
    logic               w_b;
    logic               w_s;

    state_t             r_state;
    state_t             w_state_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic               w_step_next;
    logic               w_pressed_next;
    logic               r_step;
    logic               r_pressed;

    logic [c_CNT_W-1:0] r_sc;
    logic               r_add_sub;

    // Both synchronisers reset to the idle levels: key released, count up.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_btn_sync1 <= 1'b1;
            r_btn_sync2 <= 1'b1;
            r_sw_sync1  <= 1'b1;
            r_sw_sync2  <= 1'b1;
        end else begin
            r_btn_sync1 <= BTN_N;
            r_btn_sync2 <= r_btn_sync1;
            r_sw_sync1  <= SW_DIR;
            r_sw_sync2  <= r_sw_sync1;
        end
    end

    assign w_b = ~r_btn_sync2;
    assign w_s = r_sw_sync2;

    // Direction filter runs on its own counter, independent of the key FSM.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sc      <= c_CNT_ZERO;
            r_add_sub <= 1'b1;
        end else if (w_s == r_add_sub) begin
            r_sc      <= c_CNT_ZERO;
        end else if (r_sc == c_DEB_LAST) begin
            r_add_sub <= w_s;
            r_sc      <= c_CNT_ZERO;
        end else begin
            r_sc      <= r_sc + c_CNT_ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_cnt     <= c_CNT_ZERO;
            r_step    <= 1'b0;
            r_pressed <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_step    <= w_step_next;
            r_pressed <= w_pressed_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_step_next  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // The entry sample counts as the first stable one.
                if (w_b) begin
                    w_state_next = ST_DEB_PRESS;
                    w_cnt_next   = c_CNT_ONE;
                end
            end
            ST_DEB_PRESS: begin
                if (!w_b) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = c_CNT_ZERO;
                end else if (r_cnt == c_DEB_LAST) begin
                    w_state_next = ST_HELD;
                    w_cnt_next   = c_CNT_ZERO;
                    w_step_next  = 1'b1;
                end else begin
                    w_cnt_next   = r_cnt + c_CNT_ONE;
                end
            end
            ST_HELD: begin
                if (!w_b) begin
                    w_state_next = ST_DEB_REL;
                    w_cnt_next   = c_CNT_ZERO;
                end else if (c_REPEAT && (r_cnt == c_RD_LAST)) begin
                    w_state_next = ST_REPEAT;
                    w_cnt_next   = c_CNT_ZERO;
                    w_step_next  = 1'b1;
                end else if (r_cnt != c_CNT_MAX) begin
                    w_cnt_next   = r_cnt + c_CNT_ONE;
                end
            end
            ST_REPEAT: begin
                if (!w_b) begin
                    w_state_next = ST_DEB_REL;
                    w_cnt_next   = c_CNT_ZERO;
                end else if (r_cnt == c_RP_LAST) begin
                    w_cnt_next   = c_CNT_ZERO;
                    w_step_next  = 1'b1;
                end else begin
                    w_cnt_next   = r_cnt + c_CNT_ONE;
                end
            end
            ST_DEB_REL: begin
                // A bounce back to pressed restarts repeat timing from HELD.
                if (w_b) begin
                    w_state_next = ST_HELD;
                    w_cnt_next   = c_CNT_ZERO;
                end else if (r_cnt == c_DEB_LAST) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = c_CNT_ZERO;
                end else begin
                    w_cnt_next   = r_cnt + c_CNT_ONE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = c_CNT_ZERO;
            end
        endcase
    end

    assign w_pressed_next = (w_state_next == ST_HELD)   ||
                            (w_state_next == ST_REPEAT) ||
                            (w_state_next == ST_DEB_REL);

    assign ADD_SUB = r_add_sub;
    assign STEP    = r_step;
    assign PRESSED = r_pressed;

endmodule
`default_nettype wire

// File: tb/tb_przycisk_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_przycisk_debounce
// Brief    : Directed self-checking bench for przycisk_debounce.
// Revision : 1.0 - initial release
// ============================================================================
module tb_przycisk_debounce;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic BTN_N = 1'b1;
    logic SW_DIR = 1'b1;
    logic ADD_SUB;
    logic STEP;
    logic PRESSED;

    int n_checks = 0;
    int n_fail = 0;

    przycisk_debounce #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_EN      (1),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .BTN_N  (BTN_N),
        .SW_DIR (SW_DIR),
        .ADD_SUB(ADD_SUB),
        .STEP   (STEP),
        .PRESSED(PRESSED)
    );

    always #5 CLK = ~CLK;

    task automatic do_reset();
        RST = 1'b1;
        BTN_N = 1'b1;
        SW_DIR = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        BTN_N = 1'b1;
        SW_DIR = 1'b1;
        for (int n = 0; n < 6; n++) begin
            if (n == 2) RST = 1'b0;
            @(posedge CLK);
            #1;
            n_checks += 3;
            if (ADD_SUB !== 1'b1) begin n_fail++; $display("FAIL reset_add_sub n=%0d got %b exp 1", n, ADD_SUB); end
            if (STEP !== 1'b0) begin n_fail++; $display("FAIL reset_step n=%0d got %b exp 0", n, STEP); end
            if (PRESSED !== 1'b0) begin n_fail++; $display("FAIL reset_pressed n=%0d got %b exp 0", n, PRESSED); end
        end
    endtask

    task automatic test_single_press();
        int steps = 0;
        for (int n = 0; n < 20; n++) begin
            BTN_N = (n < 8) ? 1'b0 : 1'b1;
            @(posedge CLK);
            #1;
            if (STEP === 1'b1) steps++;
            n_checks += 2;
            if (STEP !== (n == 5)) begin n_fail++; $display("FAIL press_step n=%0d got %b exp %b", n, STEP, (n == 5)); end
            if (PRESSED !== (n >= 5 && n < 14)) begin
                n_fail++; $display("FAIL press_pressed n=%0d got %b exp %b", n, PRESSED, (n >= 5 && n < 14));
            end
        end
        n_checks++;
        if (steps != 1) begin n_fail++; $display("FAIL press_step_count got %0d exp 1", steps); end
    endtask

    task automatic test_glitch();
        for (int n = 0; n < 36; n++) begin
            BTN_N = (n < 30 && (n % 6) < 3) ? 1'b0 : 1'b1;
            @(posedge CLK);
            #1;
            n_checks += 2;
            if (STEP !== 1'b0) begin n_fail++; $display("FAIL glitch_step n=%0d got %b exp 0", n, STEP); end
            if (PRESSED !== 1'b0) begin n_fail++; $display("FAIL glitch_pressed n=%0d got %b exp 0", n, PRESSED); end
        end
    endtask

    task automatic test_repeat();
        logic prev = 1'b0;
        logic exp_step;
        for (int n = 0; n < 42; n++) begin
            BTN_N = (n < 30) ? 1'b0 : 1'b1;
            @(posedge CLK);
            #1;
            exp_step = (n inside {5, 15, 18, 21, 24, 27, 30});
            n_checks += 3;
            if (STEP !== exp_step) begin n_fail++; $display("FAIL repeat_step n=%0d got %b exp %b", n, STEP, exp_step); end
            if (PRESSED !== (n >= 5 && n < 36)) begin
                n_fail++; $display("FAIL repeat_pressed n=%0d got %b exp %b", n, PRESSED, (n >= 5 && n < 36));
            end
            if (prev === 1'b1 && STEP !== 1'b0) begin n_fail++; $display("FAIL back_to_back n=%0d got %b exp 0", n, STEP); end
            prev = STEP;
        end
    endtask

    task automatic test_release_bounce();
        logic exp_step;
        for (int n = 0; n < 40; n++) begin
            BTN_N = (n < 8 || (n >= 10 && n < 27)) ? 1'b0 : 1'b1;
            @(posedge CLK);
            #1;
            exp_step = (n inside {5, 22, 25, 28});
            n_checks += 2;
            if (STEP !== exp_step) begin n_fail++; $display("FAIL bounce_step n=%0d got %b exp %b", n, STEP, exp_step); end
            if (PRESSED !== (n >= 5 && n < 33)) begin
                n_fail++; $display("FAIL bounce_pressed n=%0d got %b exp %b", n, PRESSED, (n >= 5 && n < 33));
            end
        end
    endtask

    task automatic test_direction_and_abort();
        // Switch 1->0 with a 2-cycle bounce; the change lands after edge 9.
        for (int n = 0; n < 14; n++) begin
            SW_DIR = (n < 2 || n >= 4) ? 1'b0 : 1'b1;
            @(posedge CLK);
            #1;
            n_checks += 2;
            if (ADD_SUB !== (n < 9)) begin n_fail++; $display("FAIL dir_add_sub n=%0d got %b exp %b", n, ADD_SUB, (n < 9)); end
            if (STEP !== 1'b0) begin n_fail++; $display("FAIL dir_step n=%0d got %b exp 0", n, STEP); end
        end
        // Reset on edge 3 lands in DEB_PRESS and restores ADD_SUB=1.
        for (int n = 0; n < 12; n++) begin
            SW_DIR = 1'b1;
            BTN_N = (n < 4) ? 1'b0 : 1'b1;
            RST = (n == 3);
            @(posedge CLK);
            #1;
            n_checks += 3;
            if (ADD_SUB !== (n >= 3)) begin n_fail++; $display("FAIL abort_add_sub n=%0d got %b exp %b", n, ADD_SUB, (n >= 3)); end
            if (STEP !== 1'b0) begin n_fail++; $display("FAIL abort_step n=%0d got %b exp 0", n, STEP); end
            if (PRESSED !== 1'b0) begin n_fail++; $display("FAIL abort_pressed n=%0d got %b exp 0", n, PRESSED); end
        end
        RST = 1'b0;
    endtask

    initial begin
        test_reset();
        do_reset();
        test_single_press();
        do_reset();
        test_glitch();
        do_reset();
        test_repeat();
        do_reset();
        test_release_bounce();
        do_reset();
        test_direction_and_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
